// File: rtl/truth_table_sampler.sv
// Sweeps a 4-input gate through all 16 input vectors, holding each for SETTLE
// cycles, and records the synchronized output plus a per-vector stability flag.
module truth_table_sampler #(
   parameter int SETTLE = 8,
   parameter int CNT_W  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        w_in,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic [15:0] unstable,
   output logic [0:0]  o_dbg_state
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SETTLE - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [0:0]       r_state;
   logic [3:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_s0;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_done;
   logic [15:0]      r_tt;
   logic [15:0]      r_unst;
   logic             w_s;

   assign w_s = r_sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= w_in;
         r_sync2 <= r_sync1;
      end
   end

   // r_idx returns to zero on completion, so it doubles as the abcd drive register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= 4'd0;
         r_cnt   <= '0;
         r_s0    <= 1'b0;
         r_done  <= 1'b0;
         r_tt    <= 16'h0000;
         r_unst  <= 16'h0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_idx   <= 4'd0;
                  r_cnt   <= '0;
                  r_tt    <= 16'h0000;
                  r_unst  <= 16'h0000;
                  r_done  <= 1'b0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (r_cnt == CNT_PRE) r_s0 <= w_s;
               if (r_cnt == CNT_LAST) begin
                  r_cnt         <= '0;
                  r_tt[r_idx]   <= w_s;
                  r_unst[r_idx] <= w_s ^ r_s0;
                  if (r_idx == 4'd15) begin
                     r_idx   <= 4'd0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign {a, b, c, d} = r_idx;
   assign busy         = (r_state == ST_RUN);
   assign done         = r_done;
   assign tt           = r_tt;
   assign unstable     = r_unst;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_truth_table_sampler.sv
// Randomized bench for truth_table_sampler: the gate is modelled as a 16-entry
// function table indexed by abcd, with an optional one-cycle glitch overlay.
module tb_truth_table_sampler;

   logic        clk;
   logic        rst;
   logic        start;
   logic        w_in;
   logic        a, b, c, d;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic [15:0] unstable;
   logic [0:0]  dbg_state;

   logic [15:0] func_tbl = 16'h0000;
   logic        glitch   = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   truth_table_sampler #(.SETTLE(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .w_in       (w_in),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .busy       (busy),
      .done       (done),
      .tt         (tt),
      .unstable   (unstable),
      .o_dbg_state(dbg_state)
   );

   // Gate stub: combinational function of the driven vector.
   assign w_in = func_tbl[{a, b, c, d}] | glitch;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Runs one sweep; returns the number of cycles busy was observed high.
   // ign_at >= 0 raises start for the cycle after that many edges past acceptance.
   task automatic run_sweep(input logic [15:0] fn, input int ign_at, input bit glitch_en,
                            output int busy_cycles);
      int n;
      func_tbl = fn;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         if (!busy) break;
         if (n % 8 == 4) check("abcd_step", {28'd0, a, b, c, d}, 32'(n / 8));
         if (!glitch_en && n > 0 && n % 8 == 0)
            check("tt_progress", {16'd0, tt}, {16'd0, fn & 16'((32'd1 << (n / 8)) - 1)});
         glitch = glitch_en && (n == 45);
         start  = (ign_at >= 0) && (n == ign_at);
         n++;
      end
      if (n >= 400) check("sweep_timeout", 32'(n), 32'd128);
      start       = 1'b0;
      glitch      = 1'b0;
      busy_cycles = n;
   endtask

   function automatic logic [15:0] and_ad_table();
      logic [15:0] t;
      t = 16'h0000;
      for (int i = 0; i < 16; i++) t[i] = ((i >> 3) & i & 1) != 0;
      return t;
   endfunction

   initial begin
      int          cyc;
      logic [15:0] fn;

      rst   = 1'b1;
      start = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_ctrl", {26'd0, a, b, c, d, busy, done}, 32'd0);
      check("rst_tt", {16'd0, tt}, 32'd0);
      check("rst_unst", {16'd0, unstable}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Constant-1 gate.
      run_sweep(16'hFFFF, -1, 1'b0, cyc);
      check("busy_len_ones", 32'(cyc), 32'd128);
      check("done_ones", {31'd0, done}, 32'd1);
      check("tt_ones", {16'd0, tt}, 32'h0000FFFF);
      check("unst_ones", {16'd0, unstable}, 32'd0);
      check("abcd_idle", {28'd0, a, b, c, d}, 32'd0);

      // a & d gate.
      run_sweep(and_ad_table(), -1, 1'b0, cyc);
      check("busy_len_ad", 32'(cyc), 32'd128);
      check("tt_ad", {16'd0, tt}, 32'h0000AA00);
      check("unst_ad", {16'd0, unstable}, 32'd0);

      // Constant-0 gate with a single glitch inside vector 5's sample window.
      run_sweep(16'h0000, -1, 1'b1, cyc);
      check("tt_glitch", {16'd0, tt}, 32'h00000020);
      check("unst_glitch", {16'd0, unstable}, 32'h00000020);

      // Start while busy is ignored.
      run_sweep(16'h5A3C, 30, 1'b0, cyc);
      check("busy_len_ign", 32'(cyc), 32'd128);
      check("tt_ign", {16'd0, tt}, 32'h00005A3C);

      // Start coincident with completion is ignored.
      run_sweep(16'h1234, 127, 1'b0, cyc);
      check("busy_len_end", 32'(cyc), 32'd128);
      check("end_start_busy", {31'd0, busy}, 32'd0);
      check("end_start_done", {31'd0, done}, 32'd1);
      check("end_start_tt", {16'd0, tt}, 32'h00001234);

      // Start after done clears the results on the accepting edge.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", {31'd0, busy}, 32'd1);
      check("restart_done", {31'd0, done}, 32'd0);
      check("restart_tt", {16'd0, tt}, 32'd0);
      check("restart_unst", {16'd0, unstable}, 32'd0);

      // Asynchronous reset during vector 7.
      repeat (59) @(negedge clk);
      check("pre_rst_abcd", {28'd0, a, b, c, d}, 32'd7);
      #2 rst = 1'b0;
      #1;
      check("midrst_ctrl", {26'd0, a, b, c, d, busy, done}, 32'd0);
      check("midrst_tt", {16'd0, tt}, 32'd0);
      check("midrst_unst", {16'd0, unstable}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", {31'd0, busy}, 32'd0);
      run_sweep(16'hC3A5, -1, 1'b0, cyc);
      check("busy_len_post", 32'(cyc), 32'd128);
      check("tt_post", {16'd0, tt}, 32'h0000C3A5);
      check("unst_post", {16'd0, unstable}, 32'd0);

      // Random gate functions, random gaps, random ignored starts.
      for (int t = 0; t < 8; t++) begin
         fn = 16'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_sweep(fn, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 126)) : -1, 1'b0, cyc);
         check("busy_len_rand", 32'(cyc), 32'd128);
         check("tt_rand", {16'd0, tt}, {16'd0, fn});
         check("unst_rand", {16'd0, unstable}, 32'd0);
         check("done_rand", {31'd0, done}, 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
